event_encoder_8x3: RTL and testbench
====================================

EVENT_ENCODER_8X3 -- requirements
Module: event_encoder_8x3

Interface
REQ-001 Parameter: HI_FIRST, default 1, priority order; 1 = bit 7 highest, 0 = bit 0 highest.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: In  input  8  event request lines; multi-hot permitted.
REQ-005 Port: En  input  1  capture enable; In ignored when 0.
REQ-006 Port: Out  output  3  encoded index of presented event.
REQ-007 Port: valid  output  1  Out holds an unacknowledged event.
REQ-008 Port: ready  input  1  consumer acceptance; transfer when valid && ready at a rising edge.
REQ-009 Port: pend_cnt  output  4  count of set bits in pending register (0..8), combinational from register.
REQ-010 Port: overrun  output  1  sticky flag, an event merged into an already-pending bit.
REQ-011 Port: ovr_clr  input  1  synchronous clear of overrun.
REQ-012 The block SHALL use one clock and an asynchronous active-low reset, named clk and rst_n.

Function
REQ-013 The block SHALL hold an 8-bit pending register; on each edge bit i SHALL set if En && In[i], else clear only when bit i is moved to the output stage.
REQ-014 The output stage SHALL be a two-state FSM: IDLE (valid=0) and HOLD (valid=1).
REQ-015 IDLE -> HOLD SHALL occur on an edge where pending != 0; Out SHALL load the highest-priority pending index and that pending bit SHALL clear.
REQ-016 HOLD with ready=0 SHALL keep Out and valid unchanged.
REQ-017 HOLD with ready=1 SHALL complete the transfer; if pending != 0, Out SHALL load the next highest-priority index and stay in HOLD (back-to-back, no bubble), else go to IDLE.
REQ-018 Selection SHALL use the pending register value before the same-edge capture; latency from In sampled at edge k to valid SHALL be one further edge (valid high after edge k+1) when the stage is free.
REQ-019 If In[i] arrives on the same edge bit i moves to the output stage, bit i SHALL remain set in pending as a new event; overrun SHALL NOT set.
REQ-020 If In[i] arrives while pending[i] is set and not moving out that edge, the events SHALL merge and overrun SHALL set.
REQ-021 An event for the index currently held in Out SHALL be captured normally into pending; no overrun.
REQ-022 ovr_clr SHALL clear overrun on the next edge; a simultaneous new overrun condition SHALL win (overrun stays 1).
REQ-023 In IDLE, Out SHALL retain its last loaded value.
REQ-024 With HI_FIRST=0, all selection SHALL use bit 0 as highest priority.
REQ-025 ready while valid=0 SHALL have no effect.

Reset
REQ-026 rst_n low SHALL immediately clear pending, Out=3'b000, valid=0, overrun=0, pend_cnt=0, FSM=IDLE, regardless of clk.
REQ-027 Reset asserted mid-transfer SHALL discard all pending and presented events; no event reappears after release.
REQ-028 The first capture after release SHALL occur on the first rising edge with rst_n high.

Verification
REQ-029 Single event: En=1, In=8'h10 one cycle, ready=1 -> valid high one cycle later, Out=3'd4, then IDLE, pend_cnt=0.
REQ-030 Multi-hot priority: In=8'h85 one cycle, ready=1 -> Out sequence 7,2,0 on consecutive cycles, valid continuous for 3 cycles; HI_FIRST=0 -> 0,2,7.
REQ-031 Backpressure: In=8'h06, ready=0 for 5 cycles -> Out=2 held stable, valid=1, pend_cnt=1; ready=1 -> Out=1 next cycle.
REQ-032 Overrun: In=8'h01 twice while ready=0 and bit 0 pending -> overrun=1, one event for index 0 only; ovr_clr -> overrun=0; ovr_clr coincident with new merge -> stays 1.
REQ-033 Same-edge re-arm: In[3] pulsed on edge bit 3 moves to Out -> index 3 presented twice, overrun=0.
REQ-034 Async reset: assert rst_n low between edges with valid=1, pend_cnt=3 -> all outputs zero immediately; after release with In=0, valid stays 0.

Source files
------------

// File: rtl/event_encoder_8x3.sv
// -----------------------------------------------------------------------------
// event_encoder_8x3
//
// Captures up to eight event request lines into a pending register and presents
// them one at a time, in priority order, as a 3-bit index behind a valid/ready
// handshake. Back-to-back presentation is supported: when the consumer accepts
// an index and more events are pending, the next index is loaded on the same
// edge, so valid stays high with no bubble.
//
// Parameters
//   HI_FIRST  1: bit 7 has the highest priority; 0: bit 0 has the highest.
//
// Ports
//   clk       in   1  clock, all state changes on the rising edge
//   rst_n     in   1  asynchronous active-low reset
//   In        in   8  event request lines, multi-hot allowed
//   En        in   1  capture enable; In is ignored while low
//   Out       out  3  index of the presented event
//   valid     out  1  Out holds an event not yet accepted
//   ready     in   1  consumer accepts Out when valid && ready at an edge
//   pend_cnt  out  4  number of set bits in the pending register (0..8)
//   overrun   out  1  sticky: an event merged into an already-pending bit
//   ovr_clr   in   1  synchronous clear of overrun
// -----------------------------------------------------------------------------
module event_encoder_8x3 #(
    parameter int unsigned HI_FIRST = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] In,
    input  logic       En,
    output logic [2:0] Out,
    output logic       valid,
    input  logic       ready,
    output logic [3:0] pend_cnt,
    output logic       overrun,
    input  logic       ovr_clr
);

    typedef enum logic [0:0] {
        StIdle,
        StHold
    } state_t;

    state_t     state_q;
    logic [2:0] out_q;
    logic [7:0] pending_q;
    logic [7:0] pending_d;
    logic       overrun_q;
    logic       overrun_d;

    logic [7:0] capture;
    logic [7:0] move_mask;
    logic [2:0] sel_idx;
    logic       sel_any;
    logic       advance;
    logic       merge;
    logic [3:0] cnt;

    // Highest-priority set bit of req. The loop lets the last match win, so
    // the scan direction decides which end of the vector has priority.
    function automatic logic [2:0] pick_index(input logic [7:0] req);
        logic [2:0] idx;
        idx = 3'd0;
        if (HI_FIRST != 0) begin
            for (int i = 0; i < 8; i++) begin
                if (req[i]) begin
                    idx = 3'(i);
                end
            end
        end else begin
            for (int i = 7; i >= 0; i--) begin
                if (req[i]) begin
                    idx = 3'(i);
                end
            end
        end
        return idx;
    endfunction

    // -------------------------------------------------------------------------
    // Selection and pending-register next state
    // -------------------------------------------------------------------------
    always_comb begin
        sel_idx = pick_index(pending_q);
        sel_any = |pending_q;

        // The output stage can take a new index when it is empty, or when the
        // index it holds is being accepted on this edge.
        advance   = sel_any && ((state_q == StIdle) || ready);
        move_mask = advance ? (8'b1 << sel_idx) : 8'b0;

        capture = En ? In : 8'b0;

        // Selection uses the pre-capture pending value; a capture on the bit
        // that is leaving re-arms it as a fresh event rather than merging.
        pending_d = (pending_q & ~move_mask) | capture;
        merge     = |(capture & pending_q & ~move_mask);

        // A new merge beats a simultaneous clear request.
        if (merge) begin
            overrun_d = 1'b1;
        end else if (ovr_clr) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    // Population count of the pending register.
    always_comb begin
        cnt = 4'd0;
        for (int i = 0; i < 8; i++) begin
            cnt = cnt + {3'b000, pending_q[i]};
        end
    end

    // -------------------------------------------------------------------------
    // Pending register and sticky overrun flag
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= 8'b0;
            overrun_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    // -------------------------------------------------------------------------
    // Output stage FSM. Out keeps its last loaded value while idle.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            out_q   <= 3'd0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (sel_any) begin
                        state_q <= StHold;
                        out_q   <= sel_idx;
                    end
                end
                StHold: begin
                    if (ready) begin
                        if (sel_any) begin
                            out_q <= sel_idx;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
            endcase
        end
    end

    assign Out      = out_q;
    assign valid    = (state_q == StHold);
    assign pend_cnt = cnt;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_event_encoder_8x3.sv
// -----------------------------------------------------------------------------
// tb_event_encoder_8x3
//
// Drives two encoders (bit-7-first and bit-0-first) with identical stimulus and
// compares every output after every edge against a behavioural model of the
// pending set and the presented event. Directed scenarios are followed by a
// randomized phase.
// -----------------------------------------------------------------------------
module tb_event_encoder_8x3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] in_s = 8'h00;
    logic       en_s = 1'b0;
    logic       ready_s = 1'b0;
    logic       ovr_clr_s = 1'b0;

    logic [2:0] out_hi, out_lo;
    logic       valid_hi, valid_lo;
    logic [3:0] cnt_hi, cnt_lo;
    logic       ovr_hi, ovr_lo;

    int checks = 0;
    int errors = 0;

    // Model state, index 0 = bit-7-first DUT, index 1 = bit-0-first DUT.
    logic [7:0] m_pend [2];
    int         m_out  [2];
    bit         m_valid[2];
    bit         m_ovr  [2];

    always #5 clk = ~clk;

    event_encoder_8x3 #(.HI_FIRST(1)) u_hi (
        .clk      (clk),
        .rst_n    (rst_n),
        .In       (in_s),
        .En       (en_s),
        .Out      (out_hi),
        .valid    (valid_hi),
        .ready    (ready_s),
        .pend_cnt (cnt_hi),
        .overrun  (ovr_hi),
        .ovr_clr  (ovr_clr_s)
    );

    event_encoder_8x3 #(.HI_FIRST(0)) u_lo (
        .clk      (clk),
        .rst_n    (rst_n),
        .In       (in_s),
        .En       (en_s),
        .Out      (out_lo),
        .valid    (valid_lo),
        .ready    (ready_s),
        .pend_cnt (cnt_lo),
        .overrun  (ovr_lo),
        .ovr_clr  (ovr_clr_s)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Index of the most urgent pending event, or -1 if nothing is pending.
    function automatic int most_urgent(input logic [7:0] p, input bit hi_first);
        for (int k = 0; k < 8; k++) begin
            int b;
            b = hi_first ? 7 - k : k;
            if (p[b]) return b;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_pend[d]  = 8'h00;
            m_out[d]   = 0;
            m_valid[d] = 1'b0;
            m_ovr[d]   = 1'b0;
        end
    endtask

    // One rising edge of the model, using the inputs as they stood before it.
    task automatic model_edge(input int d, input bit hi_first);
        int         leaving;
        logic [7:0] arrived;
        logic [7:0] kept;
        bit         stage_free;
        stage_free = !m_valid[d] || ready_s;
        leaving    = stage_free ? most_urgent(m_pend[d], hi_first) : -1;
        arrived    = en_s ? in_s : 8'h00;
        kept       = m_pend[d];
        if (leaving >= 0) kept[leaving] = 1'b0;
        if ((arrived & kept) != 8'h00) m_ovr[d] = 1'b1;
        else if (ovr_clr_s) m_ovr[d] = 1'b0;
        m_pend[d] = kept | arrived;
        if (leaving >= 0) begin
            m_out[d]   = leaving;
            m_valid[d] = 1'b1;
        end else if (m_valid[d] && ready_s) begin
            m_valid[d] = 1'b0;
        end
    endtask

    task automatic compare_all();
        check("hi_out",   {5'b0, out_hi},   8'(m_out[0]));
        check("hi_valid", {7'b0, valid_hi}, {7'b0, m_valid[0]});
        check("hi_cnt",   {4'b0, cnt_hi},   8'($countones(m_pend[0])));
        check("hi_ovr",   {7'b0, ovr_hi},   {7'b0, m_ovr[0]});
        check("lo_out",   {5'b0, out_lo},   8'(m_out[1]));
        check("lo_valid", {7'b0, valid_lo}, {7'b0, m_valid[1]});
        check("lo_cnt",   {4'b0, cnt_lo},   8'($countones(m_pend[1])));
        check("lo_ovr",   {7'b0, ovr_lo},   {7'b0, m_ovr[1]});
    endtask

    // Apply inputs, take one edge, update the model, check #1 later.
    task automatic cycle(input logic [7:0] in_v, input logic en_v, input logic rdy_v,
                         input logic clr_v);
        in_s      = in_v;
        en_s      = en_v;
        ready_s   = rdy_v;
        ovr_clr_s = clr_v;
        @(posedge clk);
        model_edge(0, 1'b1);
        model_edge(1, 1'b0);
        #1;
        compare_all();
    endtask

    // Assert reset between edges, hold it across one edge, release mid-cycle.
    task automatic do_reset();
        #2;
        in_s      = 8'h00;
        en_s      = 1'b0;
        ovr_clr_s = 1'b0;
        rst_n     = 1'b0;
        #1;
        model_reset();
        compare_all();
        check("rst_hi_valid_const", {7'b0, valid_hi}, 8'd0);
        @(posedge clk);
        #1;
        compare_all();
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        do_reset();

        // Single event
        cycle(8'h10, 1, 1, 0);
        cycle(8'h00, 1, 1, 0);
        check("single_out", {5'b0, out_hi}, 8'd4);
        check("single_valid", {7'b0, valid_hi}, 8'd1);
        cycle(8'h00, 1, 1, 0);
        check("single_idle", {7'b0, valid_hi}, 8'd0);
        check("single_cnt", {4'b0, cnt_hi}, 8'd0);

        // Multi-hot priority
        cycle(8'h85, 1, 1, 0);
        check("multi_cnt", {4'b0, cnt_hi}, 8'd3);
        cycle(8'h00, 1, 1, 0);
        check("multi_hi_first", {5'b0, out_hi}, 8'd7);
        check("multi_lo_first", {5'b0, out_lo}, 8'd0);
        cycle(8'h00, 1, 1, 0);
        check("multi_hi_second", {5'b0, out_hi}, 8'd2);
        check("multi_second_valid", {7'b0, valid_hi}, 8'd1);
        cycle(8'h00, 1, 1, 0);
        check("multi_hi_third", {5'b0, out_hi}, 8'd0);
        check("multi_lo_third", {5'b0, out_lo}, 8'd7);
        cycle(8'h00, 1, 1, 0);

        // Backpressure
        cycle(8'h06, 1, 0, 0);
        for (int n = 0; n < 5; n++) begin
            cycle(8'h00, 1, 0, 0);
            check("bp_out_held", {5'b0, out_hi}, 8'd2);
            check("bp_cnt", {4'b0, cnt_hi}, 8'd1);
        end
        cycle(8'h00, 1, 1, 0);
        check("bp_next", {5'b0, out_hi}, 8'd1);
        cycle(8'h00, 1, 1, 0);

        // Overrun, clear, and clear colliding with a new merge
        cycle(8'h02, 1, 0, 0);
        cycle(8'h01, 1, 0, 0);
        cycle(8'h01, 1, 0, 0);
        check("ovr_set", {7'b0, ovr_hi}, 8'd1);
        check("ovr_one_event", {4'b0, cnt_hi}, 8'd1);
        cycle(8'h00, 1, 0, 1);
        check("ovr_cleared", {7'b0, ovr_hi}, 8'd0);
        cycle(8'h01, 1, 0, 1);
        check("ovr_merge_wins", {7'b0, ovr_hi}, 8'd1);
        cycle(8'h00, 1, 1, 0);
        check("ovr_drain_idx", {5'b0, out_hi}, 8'd0);
        cycle(8'h00, 1, 1, 0);
        cycle(8'h00, 1, 1, 1);

        // Same-edge re-arm
        cycle(8'h08, 1, 1, 0);
        cycle(8'h08, 1, 1, 0);
        check("rearm_first", {5'b0, out_hi}, 8'd3);
        check("rearm_pending", {4'b0, cnt_hi}, 8'd1);
        cycle(8'h00, 1, 1, 0);
        check("rearm_second", {5'b0, out_hi}, 8'd3);
        check("rearm_valid", {7'b0, valid_hi}, 8'd1);
        check("rearm_no_ovr", {7'b0, ovr_hi}, 8'd0);
        cycle(8'h00, 1, 1, 0);

        // En low ignores In
        cycle(8'hFF, 0, 1, 0);
        check("en_low_cnt", {4'b0, cnt_hi}, 8'd0);

        // Asynchronous reset mid-transfer
        cycle(8'h01, 1, 0, 0);
        cycle(8'h0E, 1, 0, 0);
        check("pre_rst_cnt", {4'b0, cnt_hi}, 8'd3);
        check("pre_rst_valid", {7'b0, valid_hi}, 8'd1);
        do_reset();
        for (int n = 0; n < 3; n++) begin
            cycle(8'h00, 1, 1, 0);
            check("post_rst_valid", {7'b0, valid_hi}, 8'd0);
        end

        // Randomized phase
        for (int n = 0; n < 400; n++) begin
            logic [7:0] r_in;
            r_in = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
            cycle(r_in, ($urandom_range(0, 5) != 0), ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 7) == 0));
            if (n == 200) do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
